midi_transmitter: RTL and testbench

//  MIDI message transmitter; the transmit-side counterpart of MIDI_Receiver.

---
 rtl/midi_transmitter.sv | 194 +++++++++++++++++++
 tb/tb_midi_transmitter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/midi_transmitter.sv
// MIDI note-command transmitter: builds status/D1/D2 and sends them as UART 8N1.
// Optional running status (status byte skipped on repeat) under MIDI_RUNNING_STATUS_EN.
module midi_transmitter #(
    parameter int unsigned CLKS_PER_BIT = 1600
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       note_on,
    input  logic       note_off,
    input  logic [3:0] ch,
    input  logic [6:0] D1,
    input  logic [6:0] D2,
    output logic       tx,
    output logic [7:0] Dout,
    output logic       Dout_rdy,
    output logic       busy,
    output logic       done,
    output logic       error
);

    localparam int unsigned CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [2:0] NOTE_ON  = 3'b001;
    localparam logic [2:0] NOTE_OFF = 3'b000;

    typedef enum logic [1:0] {
        IDLE,
        START_BIT,
        DATA_BITS,
        STOP_BIT
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    bit_q;
    logic [1:0]    byte_q;
    logic [7:0]    status_q;
    logic [6:0]    d1_q;
    logic [6:0]    d2_q;
    logic          tx_q;
    logic [7:0]    dout_q;
    logic          rdy_q;
    logic          busy_q;
    logic          done_q;
    logic          err_q;
`ifdef MIDI_RUNNING_STATUS_EN
    logic [7:0]    last_status_q;
`endif

    logic       cmd_ok_d;
    logic       bit_end_d;
    logic       skip_d;
    logic [7:0] status_d;
    logic [7:0] next_byte_d;
    logic [2:0] bit_nx_d;

    always_comb begin
        cmd_ok_d    = note_on ^ note_off;
        status_d    = {1'b1, (note_on ? NOTE_ON : NOTE_OFF), ch};
        bit_end_d   = (cnt_q == CNT_LAST);
        bit_nx_d    = bit_q + 3'd1;
        next_byte_d = 8'h00;
        case (byte_q)
            2'd0:    next_byte_d = {1'b0, d1_q};
            2'd1:    next_byte_d = {1'b0, d2_q};
            default: next_byte_d = 8'h00;
        endcase
`ifdef MIDI_RUNNING_STATUS_EN
        // last_status resets to 0, which can never match a real status byte
        skip_d = (status_d == last_status_q);
`else
        skip_d = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            byte_q   <= '0;
            status_q <= '0;
            d1_q     <= '0;
            d2_q     <= '0;
            tx_q     <= 1'b1;
            dout_q   <= '0;
            rdy_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
`ifdef MIDI_RUNNING_STATUS_EN
            last_status_q <= '0;
`endif
        end else begin
            rdy_q  <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if (state_q != IDLE && byte_q == 2'd3) begin
                state_q <= IDLE;
                cnt_q   <= '0;
                bit_q   <= '0;
                byte_q  <= '0;
                tx_q    <= 1'b1;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        cnt_q  <= '0;
                        bit_q  <= '0;
                        tx_q   <= 1'b1;
                        busy_q <= 1'b0;
                        if (start && cmd_ok_d) begin
                            status_q <= status_d;
                            d1_q     <= D1;
                            d2_q     <= D2;
                            state_q  <= START_BIT;
                            busy_q   <= 1'b1;
                            tx_q     <= 1'b0;
                            rdy_q    <= 1'b1;
                            if (skip_d) begin
                                byte_q <= 2'd1;
                                dout_q <= {1'b0, D1};
                            end else begin
                                byte_q <= 2'd0;
                                dout_q <= status_d;
                            end
                        end else if (start) begin
                            err_q <= 1'b1;
                        end
                    end
                    START_BIT: begin
                        if (bit_end_d) begin
                            cnt_q   <= '0;
                            bit_q   <= '0;
                            tx_q    <= dout_q[0];
                            state_q <= DATA_BITS;
                        end else begin
                            cnt_q <= cnt_q + CNT_ONE;
                        end
                    end
                    DATA_BITS: begin
                        if (bit_end_d) begin
                            cnt_q <= '0;
                            if (bit_q == 3'd7) begin
                                tx_q    <= 1'b1;
                                state_q <= STOP_BIT;
                            end else begin
                                bit_q <= bit_nx_d;
                                tx_q  <= dout_q[bit_nx_d];
                            end
                        end else begin
                            cnt_q <= cnt_q + CNT_ONE;
                        end
                    end
                    STOP_BIT: begin
                        if (bit_end_d) begin
                            cnt_q <= '0;
                            if (byte_q == 2'd2) begin
                                state_q <= IDLE;
                                byte_q  <= '0;
                                tx_q    <= 1'b1;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
`ifdef MIDI_RUNNING_STATUS_EN
                                last_status_q <= status_q;
`endif
                            end else begin
                                // next start bit follows the stop bit with no gap
                                byte_q  <= byte_q + 2'd1;
                                dout_q  <= next_byte_d;
                                rdy_q   <= 1'b1;
                                tx_q    <= 1'b0;
                                state_q <= START_BIT;
                            end
                        end else begin
                            cnt_q <= cnt_q + CNT_ONE;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign tx       = tx_q;
    assign Dout     = dout_q;
    assign Dout_rdy = rdy_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign error    = err_q;

endmodule

// File: tb/tb_midi_transmitter.sv
// Bench for midi_transmitter: command table plus reset/ignore/back-to-back sequences.
// A serial decoder and a Dout_rdy monitor pop expected bytes from scoreboard queues.
module tb_midi_transmitter;

    localparam int CPB = 4;
`ifdef MIDI_RUNNING_STATUS_EN
    localparam bit RS = 1'b1;
`else
    localparam bit RS = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       note_on;
    logic       note_off;
    logic [3:0] ch;
    logic [6:0] D1;
    logic [6:0] D2;
    logic       tx;
    logic [7:0] Dout;
    logic       Dout_rdy;
    logic       busy;
    logic       done;
    logic       error;

    midi_transmitter #(.CLKS_PER_BIT(CPB)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .note_on (note_on),
        .note_off(note_off),
        .ch      (ch),
        .D1      (D1),
        .D2      (D2),
        .tx      (tx),
        .Dout    (Dout),
        .Dout_rdy(Dout_rdy),
        .busy    (busy),
        .done    (done),
        .error   (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;
    logic [7:0] exp_tx_q[$];
    logic [7:0] exp_rdy_q[$];

    function automatic void chk(input string nm, input logic [31:0] act,
                                input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    function automatic void chk_pop(input string nm, input logic [7:0] act,
                                    input bit is_tx);
        logic [7:0] e;
        if (is_tx ? exp_tx_q.size() == 0 : exp_rdy_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s: got %0h expected no byte", nm, act);
        end else begin
            e = is_tx ? exp_tx_q.pop_front() : exp_rdy_q.pop_front();
            chk(nm, 32'(act), 32'(e));
        end
    endfunction

    // serial line decoder, sampling at mid-bit
    bit         dec_busy = 1'b0;
    int         dec_cnt = 0;
    logic [7:0] dec_byte = 8'h00;
    always @(negedge clk) begin
        if (!rst_n) begin
            dec_busy = 1'b0;
        end else if (!dec_busy) begin
            if (tx === 1'b0) begin
                dec_busy = 1'b1;
                dec_cnt  = 0;
            end
        end else begin
            dec_cnt++;
            if (dec_cnt == CPB / 2) begin
                chk("start_bit", 32'(tx), 32'd0);
            end else if (dec_cnt == 9 * CPB + CPB / 2) begin
                chk("stop_bit", 32'(tx), 32'd1);
                chk_pop("tx_byte", dec_byte, 1'b1);
                dec_busy = 1'b0;
            end else if ((dec_cnt - CPB / 2) % CPB == 0) begin
                dec_byte = {tx, dec_byte[7:1]};
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && Dout_rdy === 1'b1)
            chk_pop("dout_byte", Dout, 1'b0);
    end

    typedef struct {
        logic       on;
        logic       off;
        logic [3:0] c;
        logic [6:0] d1;
        logic [6:0] d2;
        logic       acc;
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] b2;
        logic       rs;
        logic       chain;
    } vec_t;

    vec_t tbl[9];

    task automatic issue(input logic on, input logic off, input logic [3:0] c,
                         input logic [6:0] d1, input logic [6:0] d2,
                         input logic acc, input logic [7:0] b0,
                         input logic [7:0] b1, input logic [7:0] b2,
                         input logic skip, input int poke_at, input int rst_at,
                         input logic back, input logic chain);
        int n;
        int errs;
        int exp_cyc;
        if (!back) @(negedge clk);
        chk("idle_tx", 32'(tx), 32'd1);
        chk("idle_busy", 32'(busy), 32'd0);
        start = 1'b1;
        note_on = on;
        note_off = off;
        ch = c;
        D1 = d1;
        D2 = d2;
        if (acc) begin
            if (!skip) begin
                exp_tx_q.push_back(b0);
                exp_rdy_q.push_back(b0);
            end
            exp_tx_q.push_back(b1);
            exp_rdy_q.push_back(b1);
            exp_tx_q.push_back(b2);
            exp_rdy_q.push_back(b2);
        end
        @(negedge clk);
        start = 1'b0;
        chk("accept_error", 32'(error), 32'(!acc));
        chk("accept_busy", 32'(busy), 32'(acc));
        chk("accept_tx", 32'(tx), 32'(!acc));
        if (!acc) begin
            chk("reject_rdy", 32'(Dout_rdy), 32'd0);
            @(negedge clk);
            chk("reject_err_pulse", 32'(error), 32'd0);
            chk("reject_busy", 32'(busy), 32'd0);
            chk("reject_tx", 32'(tx), 32'd1);
            return;
        end
        exp_cyc = skip ? 20 * CPB : 30 * CPB;
        n = 0;
        errs = 0;
        while (done !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
            if (error === 1'b1) errs++;
            if (n == poke_at) begin
                start = 1'b1;
                note_on = 1'b1;
                note_off = 1'b0;
                ch = ~c;
                D1 = ~d1;
                D2 = ~d2;
            end else begin
                start = 1'b0;
            end
            if (n == rst_at) begin
                #2;
                rst_n = 1'b0;
                exp_tx_q.delete();
                exp_rdy_q.delete();
                #1;
                chk("rst_tx", 32'(tx), 32'd1);
                chk("rst_busy", 32'(busy), 32'd0);
                chk("rst_dout", 32'(Dout), 32'd0);
                @(negedge clk);
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
        end
        chk("done_seen", 32'(done), 32'd1);
        chk("done_latency", 32'(n), 32'(exp_cyc));
        chk("busy_at_done", 32'(busy), 32'd0);
        chk("frame_errors", 32'(errs), 32'd0);
        chk("tx_drain", 32'(exp_tx_q.size()), 32'd0);
        chk("rdy_drain", 32'(exp_rdy_q.size()), 32'd0);
        if (!chain) begin
            @(negedge clk);
            chk("done_pulse", 32'(done), 32'd0);
        end
    endtask

    initial begin
        tbl[0] = '{1'b1, 1'b0, 4'd3,  7'd26,  7'd34,  1'b1, 8'h93, 8'h1A, 8'h22, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 1'b1, 4'd8,  7'd100, 7'd115, 1'b1, 8'h88, 8'h64, 8'h73, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 1'b1, 4'd12, 7'd5,   7'd6,   1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 1'b0, 4'd1,  7'd1,   7'd1,   1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
        tbl[4] = '{1'b1, 1'b0, 4'd12, 7'd12,  7'd0,   1'b1, 8'h9C, 8'h0C, 8'h00, 1'b0, 1'b1};
        tbl[5] = '{1'b1, 1'b0, 4'd12, 7'd12,  7'd0,   1'b1, 8'h9C, 8'h0C, 8'h00, 1'b1, 1'b0};
        tbl[6] = '{1'b0, 1'b1, 4'd12, 7'd127, 7'd127, 1'b1, 8'h8C, 8'h7F, 8'h7F, 1'b0, 1'b0};
        tbl[7] = '{1'b1, 1'b1, 4'd0,  7'd9,   7'd9,   1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
        tbl[8] = '{1'b0, 1'b1, 4'd12, 7'd0,   7'd1,   1'b1, 8'h8C, 8'h00, 8'h01, 1'b1, 1'b0};

        rst_n = 1'b0;
        start = 1'b0;
        note_on = 1'b0;
        note_off = 1'b0;
        ch = '0;
        D1 = '0;
        D2 = '0;
        repeat (3) @(negedge clk);
        chk("reset_tx", 32'(tx), 32'd1);
        chk("reset_dout", 32'(Dout), 32'd0);
        chk("reset_rdy", 32'(Dout_rdy), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_error", 32'(error), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            issue(tbl[i].on, tbl[i].off, tbl[i].c, tbl[i].d1, tbl[i].d2,
                  tbl[i].acc, tbl[i].b0, tbl[i].b1, tbl[i].b2,
                  RS & tbl[i].rs, -1, -1,
                  (i > 0) ? tbl[i - 1].chain : 1'b0, tbl[i].chain);
        end

        // start while busy: ignored, no error, bytes unchanged
        issue(1'b1, 1'b0, 4'd5, 7'h40, 7'h7F, 1'b1, 8'h95, 8'h40, 8'h7F,
              1'b0, 10, -1, 1'b0, 1'b0);
        // reset in the data bits of the second byte
        issue(1'b1, 1'b0, 4'd2, 7'h11, 7'h22, 1'b1, 8'h92, 8'h11, 8'h22,
              1'b0, -1, 55, 1'b0, 1'b0);
        // full frame after reset, then running status resumes
        issue(1'b1, 1'b0, 4'd2, 7'h11, 7'h22, 1'b1, 8'h92, 8'h11, 8'h22,
              1'b0, -1, -1, 1'b0, 1'b0);
        issue(1'b1, 1'b0, 4'd2, 7'h33, 7'h44, 1'b1, 8'h92, 8'h33, 8'h44,
              RS, -1, -1, 1'b0, 1'b0);

        repeat (5) @(negedge clk);
        chk("final_tx_idle", 32'(tx), 32'd1);
        chk("final_tx_q", 32'(exp_tx_q.size()), 32'd0);
        chk("final_rdy_q", 32'(exp_rdy_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
